// File: rtl/bk_adder_arbiter.sv
// Round-robin arbiter sharing one Brent-Kung 32-bit adder among NREQ requesters.
// Optional BKARB_CHAIN_EN: per-requester carry flag for chained multi-word adds.

module brentkung32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g0, p0, gp, pp;
  logic [32:0] c;
  int          j;

  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    gp = g0;
    pp = p0;
    j  = 0;
    // Up-sweep: bit i ends up holding the group (G,P) of its aligned power-of-two span.
    for (int lvl = 0; lvl < 5; lvl++) begin
      for (int i = 0; i < 32; i++) begin
        j = i - (1 << lvl);
        if ((((i + 1) % (2 << lvl)) == 0) && (j >= 0)) begin
          gp[5'(i)] = gp[5'(i)] | (pp[5'(i)] & gp[5'(j)]);
          pp[5'(i)] = pp[5'(i)] & pp[5'(j)];
        end
      end
    end
    // Down-sweep fills the remaining prefixes so every bit covers 0..i.
    for (int lvl = 3; lvl >= 0; lvl--) begin
      for (int i = 0; i < 32; i++) begin
        j = i - (1 << lvl);
        if ((((i + 1) % (2 << lvl)) == (1 << lvl)) && ((i + 1) >= (3 << lvl)) && (j >= 0)) begin
          gp[5'(i)] = gp[5'(i)] | (pp[5'(i)] & gp[5'(j)]);
          pp[5'(i)] = pp[5'(i)] & pp[5'(j)];
        end
      end
    end
    c    = {gp | (pp & {32{cin}}), cin};
    sum  = p0 ^ c[31:0];
    cout = c[32];
  end
endmodule

// state | meaning
// EMPTY | response slot free, rsp_valid=0
// FULL  | response slot holds a result, rsp_valid=1
module bk_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_chain,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic [IDW-1:0]       rsp_id
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             any_valid;
  logic             can_issue;
  logic             accept;
  logic [31:0]      a_arr [NREQ];
  logic [31:0]      b_arr [NREQ];
  logic [31:0]      add_sum;
  logic             add_cout;
  logic             cin_sel;
  int               idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[32*gi +: 32];
    assign b_arr[gi] = req_b[32*gi +: 32];
  end

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_valid && req_valid[IDW'(idx)]) begin
        any_valid = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  assign can_issue = (state_q == EMPTY) || rsp_ready;
  assign accept    = can_issue && any_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

`ifdef BKARB_CHAIN_EN
  logic [NREQ-1:0] cflag;

  assign cin_sel = req_chain[win] ? cflag[win] : req_cin[win];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cflag <= '0;
    end else if (accept) begin
      cflag[win] <= add_cout;
    end
  end
`else
  logic unused_chain;

  assign unused_chain = ^req_chain;
  assign cin_sel      = req_cin[win];
`endif

  brentkung32 u_adder (
    .a    (a_arr[win]),
    .b    (b_arr[win]),
    .cin  (cin_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign rsp_valid = (state_q == FULL);

  // Response fields keep stale values after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
      ptr      <= '0;
    end else if (accept) begin
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= win;
      ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end
endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Self-checking bench for bk_adder_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural slot/round-robin model.
`timescale 1ns/1ps
module tb_bk_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a = '0;
  logic [NREQ*32-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_cin = '0;
  logic [NREQ-1:0]     req_chain = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;
  logic [IDW-1:0]      rsp_id;

  bk_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_full;
  logic [31:0] m_sum;
  bit          m_cout;
  int          m_id;
  int          m_ptr;
  int          m_acc = -1;
`ifdef BKARB_CHAIN_EN
  bit [NREQ-1:0] m_cflag;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_full = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
    m_acc  = -1;
`ifdef BKARB_CHAIN_EN
    m_cflag = '0;
`endif
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Compare process: outputs checked on every falling edge, model advanced for the next rising edge.
  initial begin : model_cmp
    int              w;
    bit              can;
    logic [NREQ-1:0] er;
    logic [63:0]     full;
    logic [31:0]     a, b;
    bit              ci;
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        m_reset();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_cout", rsp_cout, 0);
        chk("reset_rsp_id", rsp_id, 0);
        continue;
      end
      w   = m_winner();
      can = !m_full || rsp_ready;
      er  = '0;
      if (w >= 0 && can) er[w] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, m_full);
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_cout", rsp_cout, m_cout);
      chk("rsp_id", rsp_id, m_id);
      m_acc = -1;
      if (w >= 0 && can) begin
        a  = req_a[w*32 +: 32];
        b  = req_b[w*32 +: 32];
        ci = req_cin[w];
`ifdef BKARB_CHAIN_EN
        if (req_chain[w]) ci = m_cflag[w];
`endif
        full   = 64'(a) + 64'(b) + 64'(ci);
        m_sum  = full[31:0];
        m_cout = full[32];
`ifdef BKARB_CHAIN_EN
        m_cflag[w] = full[32];
`endif
        m_id   = w;
        m_full = 1'b1;
        m_ptr  = (w + 1) % NREQ;
        m_acc  = w;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic ch);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = ci;
    req_chain[i]      = ch;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [NREQ-1:0] sparse_rdy[4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    int sparse_id[4] = '{3, 1, 3, 1};

    // Reset then single request from requester 2
    reset_dut();
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_sum", rsp_sum, 0);
    chk("init_rsp_id", rsp_id, 0);
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("single_valid", rsp_valid, 1);
    chk("single_sum", rsp_sum, 32'h0);
    chk("single_cout", rsp_cout, 1);
    chk("single_id", rsp_id, 2);
    step();
    chk("single_drained", rsp_valid, 0);

    // All requesters valid: strict rotation
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(16 * i), 32'h1, 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, exp_order[k]);
      chk("rr_sum", rsp_sum, 32'(16 * exp_order[k] + 1));
    end

    // Backpressure while FULL, then drain and accept together
    rsp_ready = 1'b0;
    #1 chk("bp_ready", req_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready_hold", req_ready, 4'b0000);
      chk("bp_sum_stable", rsp_sum, 32'h31);
      chk("bp_id_stable", rsp_id, 3);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 4'b0001);
    step();
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_id", rsp_id, 0);
    chk("bp_release_sum", rsp_sum, 32'h1);

    // Chained 64-bit add on requester 1
    reset_dut();
    set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0010;
    step();
    chk("chain_lo_sum", rsp_sum, 32'h0);
    chk("chain_lo_cout", rsp_cout, 1);
    set_req(1, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    req_valid = '0;
`ifdef BKARB_CHAIN_EN
    chk("chain_hi_sum", rsp_sum, 32'h1);
`else
    chk("chain_hi_sum", rsp_sum, 32'h0);
`endif
    chk("chain_hi_cout", rsp_cout, 0);
    step();

    // Async reset pulse mid-cycle while FULL
    reset_dut();
    set_req(2, 32'h1234, 32'h0, 1'b0, 1'b0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    chk("arst_pre_sum", rsp_sum, 32'h1234);
    chk("arst_pre_valid", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_sum", rsp_sum, 32'h0);
    #2 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'h0, 1'b0, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 chk("arst_next_ready", req_ready, 4'b0001);
    step();
    chk("arst_next_id", rsp_id, 0);

    // Sparse requests 1 and 3 starting from ptr=2
    reset_dut();
    set_req(1, 32'h5, 32'h6, 1'b1, 1'b0);
    set_req(3, 32'h7, 32'h8, 1'b0, 1'b0);
    req_valid = 4'b0010;
    step();
    chk("sparse_setup_id", rsp_id, 1);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk("sparse_ready", req_ready, sparse_rdy[k]);
      step();
      chk("sparse_id", rsp_id, sparse_id[k]);
    end
    req_valid = '0;

    // Random traffic against the model
    reset_dut();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || m_acc == i) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom()),
                  32'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
